// File: rtl/peripheral_timer.sv
// Memory-mapped timer / I/O block at 0x40000000: reloadable 32-bit up-counter
// with prescaler and sticky overflow interrupt, plus LED, switch and 7-segment registers.
module peripheral_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] rdata,
  input  logic [7:0]  switch,
  output logic [7:0]  led,
  output logic [11:0] digi,
  output logic        irqout
);

  localparam logic [26:0] BASE_HI   = 27'h200_0000;  // 0x40000000 >> 5
  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 32'd1);

  localparam logic [2:0] IDX_TH   = 3'd0;
  localparam logic [2:0] IDX_TL   = 3'd1;
  localparam logic [2:0] IDX_TCON = 3'd2;
  localparam logic [2:0] IDX_LED  = 3'd3;
  localparam logic [2:0] IDX_SW   = 3'd4;
  localparam logic [2:0] IDX_DIGI = 3'd5;

  logic [31:0] th_r;
  logic [31:0] tl_r;
  logic [2:0]  tcon_r;
  logic [7:0]  led_r;
  logic [11:0] digi_r;
  logic [15:0] presc_r;

  logic        hit_s;
  logic [2:0]  idx_s;
  logic        wr_th_s, wr_tl_s, wr_tcon_s, wr_led_s, wr_digi_s;
  logic        tick_s;
  logic        ovf_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^addr[1:0];

  // Address decode: six word slots above the base, anything else misses.
  always_comb begin
    hit_s = 1'b0;
    idx_s = 3'd0;
    if ((addr[31:5] == BASE_HI) && (addr[4:2] <= 3'd5)) begin
      hit_s = 1'b1;
      idx_s = addr[4:2];
    end else begin
      hit_s = 1'b0;
      idx_s = 3'd0;
    end
  end

  assign wr_th_s   = wr && hit_s && (idx_s == IDX_TH);
  assign wr_tl_s   = wr && hit_s && (idx_s == IDX_TL);
  assign wr_tcon_s = wr && hit_s && (idx_s == IDX_TCON);
  assign wr_led_s  = wr && hit_s && (idx_s == IDX_LED);
  assign wr_digi_s = wr && hit_s && (idx_s == IDX_DIGI);

  assign tick_s = tcon_r[0] && (presc_r == PRESC_MAX);
  assign ovf_s  = tick_s && (tl_r == 32'hFFFF_FFFF);

  // Read mux; zero outside the map or when no read is strobed.
  always_comb begin
    rdata = 32'h0000_0000;
    if (rd && hit_s) begin
      case (idx_s)
        IDX_TH:   rdata = th_r;
        IDX_TL:   rdata = tl_r;
        IDX_TCON: rdata = {29'h0000_0000, tcon_r};
        IDX_LED:  rdata = {24'h00_0000, led_r};
        IDX_SW:   rdata = {24'h00_0000, switch};
        IDX_DIGI: rdata = {20'h0_0000, digi_r};
        default:  rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = 32'h0000_0000;
    end
  end

  // Prescaler: free-runs while enabled, parked at zero while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= 16'h0000;
    end else if (!tcon_r[0]) begin
      presc_r <= 16'h0000;
    end else if (presc_r == PRESC_MAX) begin
      presc_r <= 16'h0000;
    end else begin
      presc_r <= presc_r + 16'h0001;
    end
  end

  // Timer registers; a CPU write beats the tick update of the same register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_r   <= 32'h0000_0000;
      tl_r   <= 32'h0000_0000;
      tcon_r <= 3'b000;
    end else begin
      if (wr_th_s) begin
        th_r <= wdata;
      end
      // Reload samples th_r before this edge, so a same-cycle TH write is not seen.
      if (wr_tl_s) begin
        tl_r <= wdata;
      end else if (ovf_s) begin
        tl_r <= th_r;
      end else if (tick_s) begin
        tl_r <= tl_r + 32'h0000_0001;
      end
      if (wr_tcon_s) begin
        tcon_r <= wdata[2:0];
      end else if (ovf_s && tcon_r[1]) begin
        tcon_r[2] <= 1'b1;
      end
    end
  end

  // Board I/O registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r  <= 8'h00;
      digi_r <= 12'h000;
    end else begin
      if (wr_led_s) begin
        led_r <= wdata[7:0];
      end
      if (wr_digi_s) begin
        digi_r <= wdata[11:0];
      end
    end
  end

  assign led    = led_r;
  assign digi   = digi_r;
  assign irqout = tcon_r[2];

endmodule

// File: doc/peripheral_timer.md
# peripheral_timer

Memory-mapped timer and I/O controller on the CPU's data bus at base 0x40000000. It holds a reloadable 32-bit up-counter (TH/TL), a control/status register (TCON) that raises the CPU interrupt request on overflow, an LED register, a switch input, and a 7-segment digit register. Test programs configure it with plain sw/lw: load TH, preset TL, set TCON=3. Interrupt handlers then clear TCON[2] and update LEDs and digits.

## Interface
- PRESCALE, default 1: clock cycles per counter tick; 1 = tick every cycle; legal range 1..65535.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all registers immediately.
- addr  in  32  byte address from the MEM stage; only addr[31:2] is decoded.
- wdata  in  32  store data.
- rd  in  1  read strobe.
- wr  in  1  write strobe; sampled at rising clk.
- rdata  out  32  read data, combinational.
- switch  in  8  board switches.
- led  out  8  LED register.
- digi  out  12  7-segment register: [11:8] anode enables, [7:0] segments.
- irqout  out  1  interrupt request to the PC/exception unit; equals TCON[2].

## Operation
- Register map, offsets from 0x40000000:
  - 0x00 TH, R/W 32.
  - 0x04 TL, R/W 32.
  - 0x08 TCON, R/W [2:0]: bit0 enable, bit1 interrupt enable, bit2 interrupt status.
  - 0x0C led, R/W [7:0].
  - 0x10 switch, RO, zero-extended.
  - 0x14 digi, R/W [11:0].
- Reads:
  - rdata = selected register, zero-extended, when rd=1 and the address hits the map.
  - rdata = 0 for any other address, or when rd=0.
- Writes:
  - Take effect at the clk edge where wr=1 and the address hits the map.
  - Writes to unmapped addresses or to 0x10 are ignored.
  - TCON write loads wdata[2:0] verbatim, so software clears status by writing 0b011.
- Prescaler:
  - 16-bit counter, reset 0, runs only while TCON[0]=1.
  - Produces a tick pulse when it reaches PRESCALE-1, then wraps to 0.
  - Held at 0 while TCON[0]=0.
  - With PRESCALE=1, tick is asserted every enabled cycle.
- Counter, per tick with TCON[0]=1:
  - If TL == 0xFFFFFFFF: TL <= TH, and if TCON[1]=1 then TCON[2] <= 1.
  - Otherwise TL <= TL + 1, modulo 2^32.
  - Overflow period = (0xFFFFFFFF − TH + 1) ticks; TH=0xFFFFB4C0 gives 19264 ticks.
- Priority:
  - A CPU write to TL or TCON in the same cycle as a tick wins; the tick's update of that register is discarded.
  - A write to TH in an overflow cycle: the reload uses the old TH.
- TCON[2] is sticky: only a TCON write or reset clears it. Overflow while TCON[2]=1 leaves it 1.
- Clearing TCON[0] freezes TL and the prescaler immediately. TCON[1]=0 suppresses new status but does not clear existing status.

## Timing
- Reset values, all outputs and registers: TH=0, TL=0, TCON=0, led=0, digi=0, prescaler=0, irqout=0. rdata is combinational, so it reads 0 with rd=0.
- Write latency: new value visible on rdata and outputs in the cycle after the wr edge.
- TCON=3 written at edge N: first tick at edge N+PRESCALE, so TL increments at N+1 with PRESCALE=1.
- irqout rises in the cycle after the overflow edge and falls in the cycle after the clearing TCON write.
- Reset asserted mid-count: all state clears asynchronously; counting resumes only after software rewrites TCON.

## Test plan
- Reset behaviour:
  - Stimulus: assert reset mid-run with TL counting.
  - Required: TL, TCON, led, digi and irqout all read 0 immediately, before the next edge.
- Basic overflow:
  - Stimulus: TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3, PRESCALE=1.
  - Required: TL=0xFFFFFFFF after 1 cycle; after cycle 2, TL=0xFFFFFFF0 and irqout=1; next overflow after 16 more cycles.
- Interrupt clear and stickiness:
  - Stimulus: after irqout=1, write TCON=3.
  - Required: irqout=0 the next cycle and counting continues.
  - Stimulus: second overflow with TCON[2] already 1.
  - Required: irqout stays 1.
- Prescaler:
  - Stimulus: PRESCALE=4, TL=0, TCON=1.
  - Required: TL=1 after 4 cycles and TL=2 after 8; irqout stays 0 through overflow because TCON[1]=0.
- Write/tick collision:
  - Stimulus: write TL=0x12345678 in a tick cycle.
  - Required: TL=0x12345678, not incremented.
  - Stimulus: write TH=5 in an overflow cycle.
  - Required: TL reloads with the old TH.
- I/O registers:
  - Stimulus: switch=0xA5, then lw 0x40000010.
  - Required: rdata=0x000000A5.
  - Stimulus: sw 0x3FF to 0x40000014.
  - Required: digi=0x3FF.
  - Stimulus: read 0x40000018.
  - Required: rdata=0.
  - Stimulus: write to 0x10.
  - Required: no state change.
